// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB initiator and its wait timer.
package apb_pkg;

   localparam int APB_ADDR_W  = 8;
   localparam int APB_DATA_W  = 8;
   localparam int APB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   // A zero timeout still needs a one-bit counter to keep the ports legal.
   function automatic int timer_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired flags the last permitted ACCESS cycle.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT = APB_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = timer_width(TIMEOUT);
   localparam int unsigned LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

   generate
      if (TIMEOUT > 0) begin : g_timeout
         assign expired = (count == LAST);
      end else begin : g_no_timeout
         assign expired = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns a cmd valid/ready handshake into SETUP/ACCESS transfers
// and returns the outcome as a single-cycle rsp_valid pulse.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = APB_TIMEOUT
) (
   input  logic              PCLK,
   input  logic              RSTN,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PSLVERR,
   output logic [1:0]        fsm_state
);

   // Handshake: a command transfers on any PCLK edge where cmd_valid && cmd_ready;
   // cmd_* must stay stable while cmd_valid is high and cmd_ready is low.

   apb_state_t state, state_nxt;

   logic              psel_nxt, penable_nxt, pwrite_nxt;
   logic [ADDR_W-1:0] paddr_nxt;
   logic [DATA_W-1:0] pwdata_nxt;
   logic              rsp_valid_nxt, rsp_slverr_nxt, rsp_timeout_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;

   logic expired;
   logic in_access;
   logic done;

   assign in_access = (state == ACCESS);
   // PREADY wins over the timeout if both land on the same edge.
   assign done      = in_access && (PREADY || expired);
   assign cmd_ready = (state == IDLE) || done;
   assign fsm_state = state;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (PCLK),
      .rst_n   (RSTN),
      .clear   (!in_access || done),
      .enable  (in_access && !PREADY),
      .expired (expired)
   );

   always_comb begin
      state_nxt       = state;
      psel_nxt        = PSEL;
      penable_nxt     = PENABLE;
      pwrite_nxt      = PWRITE;
      paddr_nxt       = PADDR;
      pwdata_nxt      = PWDATA;
      rsp_valid_nxt   = 1'b0;
      rsp_rdata_nxt   = '0;
      rsp_slverr_nxt  = 1'b0;
      rsp_timeout_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nxt   = SETUP;
               psel_nxt    = 1'b1;
               penable_nxt = 1'b0;
               pwrite_nxt  = cmd_write;
               paddr_nxt   = cmd_addr;
               pwdata_nxt  = cmd_wdata;
            end
         end

         SETUP: begin
            state_nxt   = ACCESS;
            penable_nxt = 1'b1;
         end

         ACCESS: begin
            if (done) begin
               rsp_valid_nxt = 1'b1;
               if (PREADY) begin
                  rsp_slverr_nxt = PSLVERR;
                  if (!PWRITE && !PSLVERR) begin
                     rsp_rdata_nxt = PRDATA;
                  end
               end else begin
                  rsp_slverr_nxt  = 1'b1;
                  rsp_timeout_nxt = 1'b1;
               end

               if (cmd_valid) begin
                  state_nxt   = SETUP;
                  psel_nxt    = 1'b1;
                  penable_nxt = 1'b0;
                  pwrite_nxt  = cmd_write;
                  paddr_nxt   = cmd_addr;
                  pwdata_nxt  = cmd_wdata;
               end else begin
                  state_nxt   = IDLE;
                  psel_nxt    = 1'b0;
                  penable_nxt = 1'b0;
               end
            end
         end

         default: begin
            state_nxt   = IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge RSTN) begin
      if (!RSTN) begin
         state       <= IDLE;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         PSEL        <= psel_nxt;
         PENABLE     <= penable_nxt;
         PWRITE      <= pwrite_nxt;
         PADDR       <= paddr_nxt;
         PWDATA      <= pwdata_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_slverr  <= rsp_slverr_nxt;
         rsp_timeout <= rsp_timeout_nxt;
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small APB completer with
// programmable wait states, error and stall.
module tb_apb_master;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          PCLK = 1'b0;
   logic          RSTN = 1'b0;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_slverr, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic [1:0]    fsm_state;

   always #5 PCLK = ~PCLK;

   apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
      .PCLK        (PCLK),
      .RSTN        (RSTN),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PREADY      (PREADY),
      .PRDATA      (PRDATA),
      .PSLVERR     (PSLVERR),
      .fsm_state   (fsm_state)
   );

   // Completer: unwritten locations read back as ~address.
   int      wait_states = 0;
   int      acc_cnt = 0;
   logic    stall = 1'b0;
   logic    err_flag = 1'b0;
   logic [DW-1:0] mem [256];
   logic          wr_flag [256];

   assign PREADY  = PSEL && PENABLE && !stall && (acc_cnt >= wait_states);
   assign PSLVERR = err_flag;
   assign PRDATA  = wr_flag[PADDR] ? mem[PADDR] : ~PADDR;

   always @(posedge PCLK or negedge RSTN) begin
      if (!RSTN) acc_cnt <= 0;
      else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && PREADY && PWRITE) begin
         mem[PADDR]     <= PWDATA;
         wr_flag[PADDR] <= 1'b1;
      end
   end

   int rsp_cnt = 0;
   always @(negedge PCLK) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // One complete transfer with cycle-exact checks from accept to response.
   task automatic xfer(input string tag, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input int waits, input logic err,
                       input logic [7:0] exp_rdata);
      int r0;
      r0 = rsp_cnt;
      wait_states = waits;
      err_flag = err;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      check_eq({tag, "_ready_idle"}, cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      check_eq({tag, "_setup_psel"}, PSEL, 1);
      check_eq({tag, "_setup_pen"}, PENABLE, 0);
      check_eq({tag, "_setup_paddr"}, PADDR, a);
      check_eq({tag, "_setup_pwrite"}, PWRITE, w);
      check_eq({tag, "_setup_state"}, fsm_state, 1);
      if (w) check_eq({tag, "_setup_pwdata"}, PWDATA, d);
      for (int i = 0; i <= waits; i++) begin
         tick();
         check_eq({tag, "_acc_pen"}, PENABLE, 1);
         check_eq({tag, "_acc_psel"}, PSEL, 1);
         check_eq({tag, "_acc_paddr"}, PADDR, a);
         if (w) check_eq({tag, "_acc_pwdata"}, PWDATA, d);
         check_eq({tag, "_acc_ready"}, cmd_ready, (i == waits) ? 1 : 0);
         check_eq({tag, "_acc_rsp_low"}, rsp_valid, 0);
      end
      tick();
      check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
      check_eq({tag, "_rsp_slverr"}, rsp_slverr, err);
      check_eq({tag, "_rsp_timeout"}, rsp_timeout, 0);
      check_eq({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
      check_eq({tag, "_end_psel"}, PSEL, 0);
      check_eq({tag, "_end_pen"}, PENABLE, 0);
      tick();
      check_eq({tag, "_rsp_pulse"}, rsp_valid, 0);
      check_eq({tag, "_rsp_count"}, rsp_cnt - r0, 1);
      err_flag = 1'b0;
   endtask

   initial begin
      int r0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      for (int i = 0; i < 256; i++) wr_flag[i] = 1'b0;
      tick();
      tick();
      check_eq("rst_psel", PSEL, 0);
      check_eq("rst_pen", PENABLE, 0);
      check_eq("rst_paddr", PADDR, 0);
      check_eq("rst_rsp", rsp_valid, 0);
      check_eq("rst_state", fsm_state, 0);
      RSTN = 1'b1;
      tick();
      check_eq("idle_ready", cmd_ready, 1);

      xfer("t1_wr", 1'b1, 8'h10, 8'hA5, 0, 1'b0, 8'h00);
      xfer("t2_rd", 1'b0, 8'h10, 8'h00, 0, 1'b0, 8'hA5);
      xfer("t3_wr_wait", 1'b1, 8'h20, 8'h3C, 3, 1'b0, 8'h00);
      xfer("t3_rd_wait", 1'b0, 8'h22, 8'h00, 1, 1'b0, 8'hDD);
      xfer("t4_rd_err", 1'b0, 8'h02, 8'h00, 0, 1'b1, 8'h00);

      // Timeout: 16 ACCESS cycles with PREADY low, then a forced error response.
      r0 = rsp_cnt;
      stall = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33;
      tick();
      cmd_valid = 1'b0;
      check_eq("t5_setup_psel", PSEL, 1);
      for (int i = 0; i < 16; i++) begin
         tick();
         check_eq("t5_acc_pen", PENABLE, 1);
         check_eq("t5_acc_ready", cmd_ready, (i == 15) ? 1 : 0);
         check_eq("t5_acc_rsp_low", rsp_valid, 0);
      end
      tick();
      check_eq("t5_rsp_valid", rsp_valid, 1);
      check_eq("t5_rsp_timeout", rsp_timeout, 1);
      check_eq("t5_rsp_slverr", rsp_slverr, 1);
      check_eq("t5_rsp_rdata", rsp_rdata, 0);
      check_eq("t5_end_psel", PSEL, 0);
      stall = 1'b0;
      tick();
      check_eq("t5_rsp_count", rsp_cnt - r0, 1);

      // Back-to-back writes: PSEL stays high, PENABLE 0,1,0,1.
      r0 = rsp_cnt;
      wait_states = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h11;
      tick();
      check_eq("t6_s1_psel", PSEL, 1);
      check_eq("t6_s1_pen", PENABLE, 0);
      check_eq("t6_s1_paddr", PADDR, 8'h40);
      cmd_addr = 8'h41; cmd_wdata = 8'h22;
      check_eq("t6_s1_ready", cmd_ready, 0);
      tick();
      check_eq("t6_a1_psel", PSEL, 1);
      check_eq("t6_a1_pen", PENABLE, 1);
      check_eq("t6_a1_pwdata", PWDATA, 8'h11);
      check_eq("t6_a1_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      check_eq("t6_s2_psel", PSEL, 1);
      check_eq("t6_s2_pen", PENABLE, 0);
      check_eq("t6_s2_paddr", PADDR, 8'h41);
      check_eq("t6_s2_rsp", rsp_valid, 1);
      tick();
      check_eq("t6_a2_pen", PENABLE, 1);
      check_eq("t6_a2_pwdata", PWDATA, 8'h22);
      check_eq("t6_a2_rsp", rsp_valid, 0);
      tick();
      check_eq("t6_end_rsp", rsp_valid, 1);
      check_eq("t6_end_psel", PSEL, 0);
      tick();
      check_eq("t6_rsp_count", rsp_cnt - r0, 2);
      check_eq("t6_mem40", mem[8'h40], 8'h11);
      check_eq("t6_mem41", mem[8'h41], 8'h22);

      // Reset in the middle of a stalled ACCESS: immediate clear, no response.
      stall = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h66;
      tick();
      cmd_valid = 1'b0;
      tick();
      check_eq("t7_acc_pen", PENABLE, 1);
      r0 = rsp_cnt;
      #2 RSTN = 1'b0;
      #1;
      check_eq("t7_rst_psel", PSEL, 0);
      check_eq("t7_rst_pen", PENABLE, 0);
      check_eq("t7_rst_pwrite", PWRITE, 0);
      check_eq("t7_rst_paddr", PADDR, 0);
      check_eq("t7_rst_pwdata", PWDATA, 0);
      check_eq("t7_rst_state", fsm_state, 0);
      check_eq("t7_rst_rsp", rsp_valid, 0);
      tick();
      tick();
      tick();
      check_eq("t7_no_rsp", rsp_cnt - r0, 0);
      stall = 1'b0;
      RSTN = 1'b1;
      tick();
      xfer("t7_after_rst", 1'b0, 8'h10, 8'h00, 0, 1'b0, 8'hA5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
